// File: rtl/demux_rr_scheduler_pkg.sv
// Shared constants and state encoding for the demux round-robin scheduler.
package demux_rr_scheduler_pkg;

  localparam int NUM_CH      = 8;
  localparam int SEL_W       = 3;
  localparam int BURST_CNT_W = 4;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;

endpackage

// File: rtl/demux_rr_scheduler_if.sv
// Handshake and demux-drive bundle between the bit producer, the scheduler
// and the Demultiplexer_8 instance. The scheduler connects as slave.
interface demux_rr_scheduler_if;
  import demux_rr_scheduler_pkg::*;

  logic              in_valid;
  logic              in_data;
  logic              in_ready;
  logic [NUM_CH-1:0] sink_ready;
  logic [NUM_CH-1:0] ch_mask;
  logic [SEL_W-1:0]  demux_sel;
  logic              demux_enable;
  logic              demux_data;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_ch;

  modport master (
    output in_valid, in_data, sink_ready, ch_mask,
    input  in_ready, demux_sel, demux_enable, demux_data, grant_valid, grant_ch
  );

  modport slave (
    input  in_valid, in_data, sink_ready, ch_mask,
    output in_ready, demux_sel, demux_enable, demux_data, grant_valid, grant_ch
  );

endinterface

// File: rtl/rr_pick8.sv
// Rotating-priority picker: finds the first set request bit starting one
// past the last served index and wrapping through 7 back to 0.
module rr_pick8
  import demux_rr_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Walk last+1 .. last+8 with 3-bit wrap; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler sharing one serial bit source across the 8 demux
// outputs. Optional idle-timeout release is built when DEMUX_IDLE_TIMEOUT_EN
// is defined.
module demux_rr_scheduler
  import demux_rr_scheduler_pkg::*;
#(
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  demux_rr_scheduler_if.slave   bus
);

  state_t                 state_q, state_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [SEL_W-1:0]       grant_ch_q, grant_ch_d;
  logic [SEL_W-1:0]       last_ch_q, last_ch_d;
  logic [BURST_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0]       demux_sel_q, demux_sel_d;
  logic                   demux_enable_q, demux_enable_d;
  logic                   demux_data_q, demux_data_d;

  logic [NUM_CH-1:0]      elig;
  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  logic                   grant_ok;
  logic                   in_ready;
  logic                   xfer;
  logic [BURST_CNT_W-1:0] beat_cnt_inc;
  logic                   burst_done;
  logic                   timeout_hit;
  logic                   release_grant;

  assign elig         = bus.sink_ready & bus.ch_mask;
  assign grant_ok     = bus.sink_ready[grant_ch_q] & bus.ch_mask[grant_ch_q];
  assign in_ready     = (state_q == GRANT) && grant_ok;
  assign xfer         = bus.in_valid && in_ready;
  assign beat_cnt_inc = beat_cnt_q + 1'b1;
  assign burst_done   = xfer && (beat_cnt_inc == BURST_CNT_W'(BURST_LEN));

  rr_pick8 u_pick (
    .req   (elig),
    .last  (last_ch_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef DEMUX_IDLE_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  // Idle counter: zero outside a grant, cleared by transfers, counts
  // granted cycles with nothing offered.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != GRANT || xfer) begin
      idle_cnt_d = '0;
    end else if (!bus.in_valid) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (state_q == GRANT) && !bus.in_valid &&
                       ((idle_cnt_q + 8'd1) == 8'(TIMEOUT_CYCLES));

  // Idle counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // TIMEOUT_CYCLES is at least 2, so without the idle counter this never fires.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

  assign release_grant = (state_q == GRANT) && (!grant_ok || burst_done || timeout_hit);

  // Next-state logic: arbitration in IDLE, transfers and release in GRANT.
  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_ch_d     = grant_ch_q;
    last_ch_d      = last_ch_q;
    beat_cnt_d     = beat_cnt_q;
    demux_sel_d    = demux_sel_q;
    demux_enable_d = 1'b0;
    demux_data_d   = 1'b0;

    if (state_q == IDLE) begin
      if (pick_found) begin
        state_d       = GRANT;
        grant_valid_d = 1'b1;
        grant_ch_d    = pick_idx;
        beat_cnt_d    = '0;
      end
    end else begin
      if (xfer) begin
        demux_enable_d = 1'b1;
        demux_sel_d    = grant_ch_q;
        demux_data_d   = bus.in_data;
        beat_cnt_d     = beat_cnt_inc;
      end
      if (release_grant) begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
        last_ch_d     = grant_ch_q;
      end
    end
  end

  // State and output registers; reset drops any grant and in-flight bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_valid_q  <= 1'b0;
      grant_ch_q     <= '0;
      last_ch_q      <= SEL_W'(NUM_CH - 1);
      beat_cnt_q     <= '0;
      demux_sel_q    <= '0;
      demux_enable_q <= 1'b0;
      demux_data_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_ch_q     <= grant_ch_d;
      last_ch_q      <= last_ch_d;
      beat_cnt_q     <= beat_cnt_d;
      demux_sel_q    <= demux_sel_d;
      demux_enable_q <= demux_enable_d;
      demux_data_q   <= demux_data_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.demux_sel    = demux_sel_q;
  assign bus.demux_enable = demux_enable_q;
  assign bus.demux_data   = demux_data_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_ch     = grant_ch_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed testbench for demux_rr_scheduler and its rr_pick8 picker.
module tb_demux_rr_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  demux_rr_scheduler_if bus();

  demux_rr_scheduler #(.BURST_LEN(4), .TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] pick_req;
  logic [2:0] pick_last;
  logic       pick_found;
  logic [2:0] pick_idx;

  rr_pick8 u_pick (
    .req   (pick_req),
    .last  (pick_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [7:0] sink_ready;
    logic [7:0] ch_mask;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       grant_valid;
    logic [2:0] grant_ch;
    logic       demux_enable;
    logic [2:0] demux_sel;
    logic       demux_data;
  } vec_t;

  typedef struct {
    logic [7:0] req;
    logic [2:0] last;
    logic       found;
    logic [2:0] idx;
  } pick_vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] sr, input logic [7:0] cm,
                               input logic v, input logic d);
    bus.sink_ready = sr;
    bus.ch_mask    = cm;
    bus.in_valid   = v;
    bus.in_data    = d;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t       t1 [8];
  pick_vec_t  pv [7];
  logic [2:0] grants [4];
  logic [2:0] exp_grants [4];
  int         n_grants;
  int         bad;
  int         held;
  logic       prev_gv;

  initial begin
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    pick_req  = '0;
    pick_last = '0;

    // sink, mask, valid, data | in_ready, gv, gch, en, sel, data
    t1[0] = '{8'hFF, 8'hFF, 1, 1, 0, 0, 3'd0, 0, 3'd0, 0};
    t1[1] = '{8'hFF, 8'hFF, 1, 1, 1, 1, 3'd0, 0, 3'd0, 0};
    t1[2] = '{8'hFF, 8'hFF, 1, 0, 1, 1, 3'd0, 1, 3'd0, 1};
    t1[3] = '{8'hFF, 8'hFF, 1, 1, 1, 1, 3'd0, 1, 3'd0, 0};
    t1[4] = '{8'hFF, 8'hFF, 1, 0, 1, 1, 3'd0, 1, 3'd0, 1};
    t1[5] = '{8'hFF, 8'hFF, 1, 1, 0, 0, 3'd0, 1, 3'd0, 0};
    t1[6] = '{8'hFF, 8'hFF, 1, 1, 1, 1, 3'd1, 0, 3'd0, 0};
    t1[7] = '{8'hFF, 8'hFF, 1, 0, 1, 1, 3'd1, 1, 3'd1, 1};

    pv[0] = '{8'b0100_0001, 3'd6, 1, 3'd0};
    pv[1] = '{8'b0100_0001, 3'd5, 1, 3'd6};
    pv[2] = '{8'h00,        3'd3, 0, 3'd0};
    pv[3] = '{8'hFF,        3'd7, 1, 3'd0};
    pv[4] = '{8'h80,        3'd7, 1, 3'd7};
    pv[5] = '{8'h01,        3'd0, 1, 3'd0};
    pv[6] = '{8'h10,        3'd2, 1, 3'd4};

    exp_grants[0] = 3'd2;
    exp_grants[1] = 3'd7;
    exp_grants[2] = 3'd2;
    exp_grants[3] = 3'd7;

    // Standalone picker vectors.
    for (int i = 0; i < 7; i++) begin
      pick_req  = pv[i].req;
      pick_last = pv[i].last;
      #1;
      checkOutput($sformatf("pick[%0d].found", i), 8'(pick_found), 8'(pv[i].found));
      if (pv[i].found) checkOutput($sformatf("pick[%0d].idx", i), 8'(pick_idx), 8'(pv[i].idx));
    end

    // Reset followed by a full burst on channel 0, then a grant on channel 1.
    applyReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(t1[i].sink_ready, t1[i].ch_mask, t1[i].in_valid, t1[i].in_data);
      #1;
      checkOutput($sformatf("t1[%0d].in_ready", i), 8'(bus.in_ready), 8'(t1[i].in_ready));
      checkOutput($sformatf("t1[%0d].grant_valid", i), 8'(bus.grant_valid), 8'(t1[i].grant_valid));
      checkOutput($sformatf("t1[%0d].grant_ch", i), 8'(bus.grant_ch), 8'(t1[i].grant_ch));
      checkOutput($sformatf("t1[%0d].demux_enable", i), 8'(bus.demux_enable), 8'(t1[i].demux_enable));
      checkOutput($sformatf("t1[%0d].demux_sel", i), 8'(bus.demux_sel), 8'(t1[i].demux_sel));
      checkOutput($sformatf("t1[%0d].demux_data", i), 8'(bus.demux_data), 8'(t1[i].demux_data));
      tick();
    end

    // Two eligible channels alternate, never touching any other select.
    applyStimulus(8'hFF, 8'b1000_0100, 1'b1, 1'b1);
    applyReset();
    n_grants = 0;
    bad      = 0;
    prev_gv  = 1'b0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      tick();
      if (bus.grant_valid && !prev_gv) begin
        grants[n_grants] = bus.grant_ch;
        n_grants++;
      end
      if (bus.demux_enable && bus.demux_sel != 3'd2 && bus.demux_sel != 3'd7) bad++;
      prev_gv = bus.grant_valid;
    end
    checkOutput("t2.grant_count", 8'(n_grants), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_grants) checkOutput($sformatf("t2.grant[%0d]", i), 8'(grants[i]), 8'(exp_grants[i]));
    end
    checkOutput("t2.stray_sel", 8'(bad), 8'd0);

    // Sink 3 drops ready mid-burst; the next grant starts a fresh burst on 4.
    applyStimulus(8'hFF, 8'b0001_1000, 1'b1, 1'b1);
    applyReset();
    tick();
    checkOutput("t3.grant_ch3", 8'(bus.grant_ch), 8'd3);
    tick();
    tick();
    applyStimulus(8'hF7, 8'b0001_1000, 1'b1, 1'b1);
    #1;
    checkOutput("t3.in_ready_drop", 8'(bus.in_ready), 8'd0);
    checkOutput("t3.gv_before_release", 8'(bus.grant_valid), 8'd1);
    tick();
    checkOutput("t3.released", 8'(bus.grant_valid), 8'd0);
    tick();
    checkOutput("t3.regrant_valid", 8'(bus.grant_valid), 8'd1);
    checkOutput("t3.regrant_ch4", 8'(bus.grant_ch), 8'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t3.beat%0d_in_ready", k), 8'(bus.in_ready), 8'd1);
      checkOutput($sformatf("t3.beat%0d_gv", k), 8'(bus.grant_valid), 8'd1);
      tick();
    end
    checkOutput("t3.full_burst_release", 8'(bus.grant_valid), 8'd0);
    checkOutput("t3.last_sel", 8'(bus.demux_sel), 8'd4);
    checkOutput("t3.last_enable", 8'(bus.demux_enable), 8'd1);

    // Reset right after a transfer on channel 5 clears everything.
    applyStimulus(8'hFF, 8'b0010_0000, 1'b1, 1'b1);
    applyReset();
    tick();
    tick();
    checkOutput("t4.pre_enable", 8'(bus.demux_enable), 8'd1);
    checkOutput("t4.pre_sel", 8'(bus.demux_sel), 8'd5);
    reset = 1'b1;
    tick();
    checkOutput("t4.enable", 8'(bus.demux_enable), 8'd0);
    checkOutput("t4.sel", 8'(bus.demux_sel), 8'd0);
    checkOutput("t4.data", 8'(bus.demux_data), 8'd0);
    checkOutput("t4.grant_valid", 8'(bus.grant_valid), 8'd0);
    checkOutput("t4.grant_ch", 8'(bus.grant_ch), 8'd0);
    checkOutput("t4.in_ready", 8'(bus.in_ready), 8'd0);
    applyStimulus(8'hFF, 8'b0010_0100, 1'b1, 1'b1);
    reset = 1'b0;
    tick();
    checkOutput("t4.post_gv", 8'(bus.grant_valid), 8'd1);
    checkOutput("t4.post_ch", 8'(bus.grant_ch), 8'd2);

    // Grant on channel 1 with nothing offered.
    applyStimulus(8'hFF, 8'b0000_0110, 1'b0, 1'b0);
    applyReset();
    tick();
    checkOutput("t5.grant_ch1", 8'(bus.grant_ch), 8'd1);
    held = 0;
`ifdef DEMUX_IDLE_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.grant_valid && bus.grant_ch == 3'd1) held++;
    end
    checkOutput("t5.held_cycles", 8'(held), 8'd15);
    tick();
    checkOutput("t5.timeout_release", 8'(bus.grant_valid), 8'd0);
    tick();
    checkOutput("t5.next_gv", 8'(bus.grant_valid), 8'd1);
    checkOutput("t5.next_ch", 8'(bus.grant_ch), 8'd2);
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.grant_valid && bus.grant_ch == 3'd1) held++;
    end
    checkOutput("t5.held_cycles", 8'(held), 8'd100);
`endif

    // Everything masked: no grant, no ready, no output.
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    applyReset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.in_ready || bus.demux_enable || bus.grant_valid) bad++;
      tick();
    end
    checkOutput("t6.masked_activity", 8'(bad), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Round-robin scheduler that shares one serial bit source between the 8 outputs of the team's 8-way demultiplexer.
- Accepts bits over a valid/ready handshake and picks a ready, unmasked sink in rotating order.
- Holds that sink for a burst and drives the demux sel/enable/data inputs from registers.
- Sits between the upstream bit producer and the Demultiplexer_8 instance.

Parameters:
- BURST_LEN, 4: transfers granted to one channel before the grant is released (1..15).
- TIMEOUT_CYCLES, 16: idle cycles before forced release; used only with the optional feature (2..255).

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  source has a bit
- in_data  in  1  source bit
- in_ready  out  1  scheduler accepts in_data this cycle (combinational)
- sink_ready  in  8  per-channel ready from the consumers
- ch_mask  in  8  1 = channel eligible for arbitration
- demux_sel  out  3  registered select to the demux
- demux_enable  out  1  registered enable to the demux; high for exactly one cycle per transfer
- demux_data  out  1  registered data to the demux
- grant_valid  out  1  a channel currently holds the grant
- grant_ch  out  3  index of the granted channel

Behaviour:
- Reset values: demux_sel=0, demux_enable=0, demux_data=0, grant_valid=0, grant_ch=0, state=IDLE, beat_cnt=0, last_ch=7. With last_ch=7 the first search starts at channel 0.
- Reset mid-burst drops the grant immediately. An in-flight registered output is cleared; it is not completed.
- States: IDLE, GRANT.
- IDLE, eligibility: elig = sink_ready & ch_mask.
  - If elig != 0, pick the first set bit searching (last_ch+1) mod 8 upward with wrap.
  - On the next edge: grant_ch=pick, grant_valid=1, beat_cnt=0, go to GRANT.
  - If elig == 0, stay in IDLE.
- GRANT, handshake: in_ready = sink_ready[grant_ch] & ch_mask[grant_ch]. A transfer occurs when in_valid & in_ready.
- GRANT, on a transfer (next edge):
  - demux_enable=1, demux_sel=grant_ch, demux_data=in_data, beat_cnt++.
  - Latency from accepted bit to demux output is 1 cycle.
- Outputs when no transfer: demux_enable=0 and demux_data=0; demux_sel holds its value.
- GRANT, release conditions (any one):
  - the transfer makes beat_cnt reach BURST_LEN;
  - sink_ready[grant_ch]=0;
  - ch_mask[grant_ch]=0.
- On release (next edge): state=IDLE, grant_valid=0, last_ch=grant_ch.
- A final transfer and a release in the same cycle are both honoured: the bit is output, then the grant is released.
- Re-arbitration costs one IDLE cycle, so there are no back-to-back grants.
- in_ready is 0 in IDLE, so no bit is ever lost.
- Single eligible channel: it is re-granted after one IDLE cycle.
- All channels masked: the scheduler stays in IDLE with in_ready=0.
- Wrap-around: last_ch=6 with elig=8'b0100_0001 picks 0 ahead of 6 (7→0 ordering).
- beat_cnt is 4 bits wide. grant_ch and last_ch are 3 bits, and the pick arithmetic is mod 8.

Optional Feature:
- Macro: DEMUX_IDLE_TIMEOUT_EN.
- With the macro:
  - An 8-bit idle counter clears on each transfer or new grant, and increments in GRANT when in_valid=0.
  - When it reaches TIMEOUT_CYCLES, the grant is released as a normal release (last_ch updated).
  - Counter reset value is 0.
- Without the macro: no counter exists. The grant persists until the burst completes or the sink drops ready or mask.

Decomposition:
- Shared package holds: NUM_CH=8, SEL_W=3, state typedef (IDLE=1'b0, GRANT=1'b1), BURST_CNT_W=4.
- One natural sub-module: rr_pick8. It is combinational: 8-bit request plus 3-bit last index in; found flag plus 3-bit index out, rotating priority.
- Also instantiate and test rr_pick8 standalone.

Test Plan:
- Reset, then elig=8'hFF, in_valid=1, data alternating 1,0,1,0 → grant_ch=0, four 1-cycle demux_enable pulses with sel=0, data 1,0,1,0; release, one IDLE cycle, next grant_ch=1.
- ch_mask=8'b1000_0100, sink_ready=8'hFF, in_valid held high over two bursts → grants alternate 2,7,2,7; never any other sel.
- Drop sink_ready[3] after 2 beats of a grant on channel 3 → in_ready falls the same cycle, grant released next edge, beat_cnt not carried, next grant is channel 4 if eligible.
- Assert reset in the cycle after a transfer on channel 5 → next cycle all outputs 0, grant_valid=0; first post-reset grant is the lowest eligible channel from 0.
- With DEMUX_IDLE_TIMEOUT_EN and TIMEOUT_CYCLES=16: grant channel 1, hold in_valid=0 → release on cycle 16, grant moves to channel 2. Without the macro, the same stimulus holds channel 1 for 100 cycles.
- All channels masked, in_valid=1 for 20 cycles → in_ready=0, demux_enable=0, grant_valid=0 throughout.
